// File: rtl/modinv_helper_load.sv
// modinv_helper_load
//   Copies an OPERAND_NUM_WORDS-word operand from a 1-cycle-latency operand bank into
//   a BUFFER_NUM_WORDS-word buffer. Buffer words above the operand are zero-filled.
//   A run is started by ena while rdy=1 and lasts PROC_NUM_CYCLES cycles.
//
// Ports
//   clk     clock
//   rst     synchronous active-high reset
//   ena     start request, sampled only while rdy=1
//   rdy     idle/complete flag (proc_cnt == 0)
//   a_addr  operand bank read address (registered)
//   a_din   operand bank read data, valid one cycle after a_addr
//   b_addr  buffer write address (registered)
//   b_wren  buffer write enable
//   b_dout  buffer write data
module modinv_helper_load #(
  parameter int unsigned OPERAND_NUM_WORDS = 8,
  parameter int unsigned OPERAND_ADDR_BITS = 3,
  parameter int unsigned BUFFER_NUM_WORDS  = 9,
  parameter int unsigned BUFFER_ADDR_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  output logic                         rdy,
  output logic [OPERAND_ADDR_BITS-1:0] a_addr,
  input  logic [31:0]                  a_din,
  output logic [BUFFER_ADDR_BITS-1:0]  b_addr,
  output logic                         b_wren,
  output logic [31:0]                  b_dout
);

  localparam int unsigned PROC_NUM_CYCLES = BUFFER_NUM_WORDS + 2;
  localparam int unsigned CNT_BITS        = $clog2(PROC_NUM_CYCLES);

  typedef logic [CNT_BITS-1:0] cnt_t;

  localparam cnt_t CNT_ONE      = cnt_t'(1);
  localparam cnt_t CNT_TWO      = cnt_t'(2);
  localparam cnt_t CNT_LAST     = cnt_t'(PROC_NUM_CYCLES - 1);
  localparam cnt_t CNT_RD_LAST  = cnt_t'(OPERAND_NUM_WORDS);
  localparam cnt_t CNT_WR_LAST  = cnt_t'(BUFFER_NUM_WORDS + 1);

  localparam logic [BUFFER_ADDR_BITS-1:0] B_COPY_END = BUFFER_ADDR_BITS'(OPERAND_NUM_WORDS);

  cnt_t                         r_proc_cnt;
  cnt_t                         w_cnt_next;
  cnt_t                         w_cnt_m1;
  cnt_t                         w_cnt_m2;
  logic [OPERAND_ADDR_BITS-1:0] r_a_addr;
  logic [OPERAND_ADDR_BITS-1:0] w_a_addr_next;
  logic [BUFFER_ADDR_BITS-1:0]  r_b_addr;
  logic [BUFFER_ADDR_BITS-1:0]  w_b_addr_next;
  logic                         w_in_wr_window;

  // State register: proc_cnt plus the address registers that track it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proc_cnt <= '0;
      r_a_addr   <= '0;
      r_b_addr   <= '0;
    end else begin
      r_proc_cnt <= w_cnt_next;
      r_a_addr   <= w_a_addr_next;
      r_b_addr   <= w_b_addr_next;
    end
  end

  // Next-state logic. Addresses are derived from the next count so that the registered
  // value lines up with proc_cnt in the same cycle.
  always_comb begin
    w_cnt_next = r_proc_cnt;
    if (r_proc_cnt == '0) begin
      w_cnt_next = ena ? CNT_ONE : '0;
    end else if (r_proc_cnt == CNT_LAST) begin
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_proc_cnt + CNT_ONE;
    end

    w_cnt_m1 = w_cnt_next - CNT_ONE;
    w_cnt_m2 = w_cnt_next - CNT_TWO;

    // Read window 1..OPERAND_NUM_WORDS; the cycle after it reads back address 0.
    w_a_addr_next = '0;
    if ((w_cnt_next >= CNT_ONE) && (w_cnt_next <= CNT_RD_LAST)) begin
      w_a_addr_next = OPERAND_ADDR_BITS'(w_cnt_m1);
    end

    w_b_addr_next = '0;
    if ((w_cnt_next >= CNT_TWO) && (w_cnt_next <= CNT_WR_LAST)) begin
      w_b_addr_next = BUFFER_ADDR_BITS'(w_cnt_m2);
    end
  end

  // Outputs. The write strobe is also masked by rst so an abort takes effect in the
  // very cycle rst is raised, not one cycle later.
  always_comb begin
    rdy            = (r_proc_cnt == '0);
    w_in_wr_window = (r_proc_cnt >= CNT_TWO) && (r_proc_cnt <= CNT_WR_LAST);
    b_wren         = w_in_wr_window && !rst;
    // Operand data lags a_addr by one cycle, so b_addr (= proc_cnt-2) indexes a_din.
    b_dout         = (b_wren && (r_b_addr < B_COPY_END)) ? a_din : 32'h0;
    a_addr         = r_a_addr;
    b_addr         = r_b_addr;
  end

endmodule
